// File: rtl/decimator_pkg.sv
// Shared audio-stream types and default constants.
// Used by the filter and decimator stages.
package decimator_pkg;

  localparam int DEF_W      = 32;
  localparam int DEF_W_FRAC = 16;
  localparam int DEF_M      = 4;

  typedef logic signed [DEF_W-1:0] sample_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/decimator_stream_out_reg.sv
// One-entry valid/ready output holding register.
// Loads only when empty or being drained in the same cycle.
module stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         load_ready
);

  assign load_ready = !valid || ready;

  // Hold while stalled; load wins over drain so there is no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decimator.sv
// Decimate-by-M stream stage with valid/ready handshakes.
// DECIM_AVG_EN: output the floor mean of each group instead of picking.
module decimator
  import decimator_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int W_FRAC = DEF_W_FRAC,
  parameter int M      = DEF_M
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data
);

  localparam int PW = $clog2(M);
  localparam logic [PW-1:0] LAST = PW'(M - 1);

  if (!is_pow2(M) || W_FRAC < 0 || W_FRAC > W) begin : g_bad_cfg
    $error("decimator: bad W/W_FRAC/M");
  end

  logic [PW-1:0] phase;
  logic          at_last;
  logic          accept;
  logic          complete;
  logic          out_ready;
  logic [W-1:0]  y_next;

  assign at_last  = (phase == LAST);
  assign x_ready  = !at_last || out_ready;
  assign accept   = x_valid && x_ready;
  assign complete = accept && at_last;

  // Phase advances per accepted sample, wrapping after the group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (accept) begin
      phase <= at_last ? '0 : phase + 1'b1;
    end
  end

`ifdef DECIM_AVG_EN
  localparam int AW = W + PW;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] sum;

  assign x_ext  = {{PW{x_data[W-1]}}, x_data};
  assign sum    = acc + x_ext;
  assign y_next = W'(sum >>> PW);

  // Phase 0 restarts the sum; later non-final phases add into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (accept && !at_last) begin
      acc <= (phase == '0) ? x_ext : sum;
    end
  end
`else
  assign y_next = x_data;
`endif

  stream_out_reg #(
    .W(W)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (complete),
    .d         (y_next),
    .ready     (y_ready),
    .valid     (y_valid),
    .q         (y_data),
    .load_ready(out_ready)
  );

endmodule

// File: tb/tb_decimator.sv
// Self-checking bench for decimator (W=32, M=4).
// Honours DECIM_AVG_EN for expected values.
module tb_decimator;
  import decimator_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_data;
  logic        y_valid;
  logic        y_ready;
  logic [31:0] y_data;

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;

  logic [31:0] sb[$];
  int n_acc = 0;
  int pops = 0;

  typedef struct {
    sample_t     x [4];
    logic [31:0] e_pick;
    logic [31:0] e_avg;
  } vec_t;

  vec_t tab [8];

  decimator #(.W(32), .W_FRAC(16), .M(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data (x_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_data (y_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec_exp(input vec_t v);
`ifdef DECIM_AVG_EN
    return v.e_avg;
`else
    return v.e_pick;
`endif
  endfunction

  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    x_valid = 1'b1;
    x_data  = v;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = x_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %h", v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent cycle model plus output scoreboard.
  task automatic monitor();
    logic [1:0]  m_phase = 0;
    logic        m_yv = 0;
    logic [31:0] m_yd = 0;
    longint      m_acc = 0;
    longint      xs;
    logic [31:0] res;
    logic [31:0] e;
    logic        exp_xr;
    logic        acc_x;
    logic        drain;
    while (!done) begin
      @(negedge clk);
      if (reset) begin
        m_phase = 0;
        m_yv = 0;
        m_yd = 0;
        m_acc = 0;
        sb.delete();
        n_acc = 0;
        pops = 0;
        continue;
      end
      exp_xr = (m_phase != 2'd3) || !m_yv || y_ready;
      chk("x_ready", {31'd0, x_ready}, {31'd0, exp_xr});
      chk("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
      if (m_yv) chk("y_data", y_data, m_yd);
      if (y_valid && y_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %h expected no output", y_data);
        end else begin
          e = sb.pop_front();
          chk("sb_y_data", y_data, e);
          pops++;
        end
      end
      if (x_valid && x_ready) n_acc++;
      acc_x = x_valid && exp_xr;
      drain = m_yv && y_ready;
      if (acc_x) begin
        xs = longint'($signed(x_data));
        m_acc = (m_phase == 0) ? xs : m_acc + xs;
      end
      if (acc_x && m_phase == 2'd3) begin
`ifdef DECIM_AVG_EN
        res = 32'(m_acc >>> 2);
`else
        res = x_data;
`endif
        sb.push_back(res);
        m_yv = 1'b1;
        m_yd = res;
      end else if (drain) begin
        m_yv = 1'b0;
      end
      if (acc_x) m_phase = m_phase + 2'd1;
    end
  endtask

  task automatic stimulus();
    logic [31:0] ea;
    logic [31:0] eb;
    int acc_cnt;
    int cyc;

    tab[0] = '{'{32'd4, 32'd8, 32'd12, 32'd16}, 32'd16, 32'd10};
    tab[1] = '{'{32'd20, 32'd24, 32'd28, 32'd32}, 32'd32, 32'd26};
    tab[2] = '{'{-32'sd1, -32'sd1, -32'sd1, -32'sd2},
               32'hFFFF_FFFE, 32'hFFFF_FFFE};
    tab[3] = '{'{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 32'h7FFF_FFFF}, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tab[4] = '{'{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 32'h8000_0000}, 32'h8000_0000, 32'h8000_0000};
    tab[5] = '{'{-32'sd3, 32'd0, 32'd0, 32'd0}, 32'd0, 32'hFFFF_FFFF};
    tab[6] = '{'{32'd1, 32'd2, 32'd3, 32'd5}, 32'd5, 32'd2};
    tab[7] = '{'{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                 32'h8000_0000}, 32'h8000_0000, 32'hFFFF_FFFF};

    reset   = 1'b1;
    x_valid = 1'b0;
    x_data  = 32'h0;
    y_ready = 1'b1;
    step();
    step();
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y_data", y_data, 32'd0);
    chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Continuous groups with downstream always ready.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        send(tab[v].x[i]);
        if (i < 3) begin
          chk($sformatf("tab%0d_idle%0d", v, i), {31'd0, y_valid}, 32'd0);
        end else begin
          chk($sformatf("tab%0d_valid", v), {31'd0, y_valid}, 32'd1);
          chk($sformatf("tab%0d_data", v), y_data, vec_exp(tab[v]));
        end
      end
    end
    x_valid = 1'b0;
    step();
    step();

    // Stalled output: phases 0..2 still accepted, phase 3 blocked.
`ifdef DECIM_AVG_EN
    ea = 32'd250;
    eb = 32'd3;
`else
    ea = 32'd400;
    eb = 32'd9;
`endif
    y_ready = 1'b0;
    send(32'd100);
    send(32'd200);
    send(32'd300);
    send(32'd400);
    chk("stall_valid", {31'd0, y_valid}, 32'd1);
    chk("stall_data", y_data, ea);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    chk("stall_hold", y_data, ea);
    x_valid = 1'b1;
    x_data  = 32'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_xr", {31'd0, x_ready}, 32'd0);
      chk("stall_yd", y_data, ea);
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    @(negedge clk);
    chk("unstall_xr", {31'd0, x_ready}, 32'd1);
    step();
    chk("nobubble_valid", {31'd0, y_valid}, 32'd1);
    chk("nobubble_data", y_data, eb);
    x_valid = 1'b0;

    // Pending output plus partial group, then reset.
`ifdef DECIM_AVG_EN
    ea = 32'd20;
    eb = 32'd41;
`else
    ea = 32'd1;
    eb = 32'd44;
`endif
    send(32'd77);
    y_ready = 1'b0;
    send(32'd1);
    send(32'd1);
    send(32'd1);
    chk("pre_rst_data", y_data, ea);
    send(32'd5);
    send(32'd6);
    x_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_y_valid", {31'd0, y_valid}, 32'd0);
    chk("async_y_data", y_data, 32'd0);
    chk("async_x_ready", {31'd0, x_ready}, 32'd1);
    step();
    reset = 1'b0;
    y_ready = 1'b1;
    step();
    send(32'd40);
    chk("post_rst_p0", {31'd0, y_valid}, 32'd0);
    send(32'd40);
    send(32'd40);
    chk("post_rst_p2", {31'd0, y_valid}, 32'd0);
    send(32'd44);
    chk("post_rst_valid", {31'd0, y_valid}, 32'd1);
    chk("post_rst_data", y_data, eb);
    x_valid = 1'b0;
    step();
    step();
    chk("post_rst_one", {31'd0, y_valid}, 32'd0);

    // Random valid/ready traffic against the model.
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      x_valid = ($urandom_range(0, 9) < 7);
      x_data  = $urandom;
      y_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (x_valid && x_ready) acc_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (acc_cnt < 10000) begin
      checks++;
      errors++;
      $display("FAIL rand_timeout: got %0d accepts expected 10000", acc_cnt);
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    repeat (4) step();
    chk("sb_empty", sb.size(), 32'd0);
    chk("out_count", pops, n_acc / 4);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
